// File: rtl/demux4_stream_if.sv
// demux4_stream_if: producer-side and consumer-side stream signals of the 1-to-4 demux; bcast exists only with DEMUX4_BCAST_EN
interface demux4_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [2:0]       occ;
`ifdef DEMUX4_BCAST_EN
  logic             bcast;
  modport master (output d, sel, in_valid, out_ready, bcast, input in_ready, y0, y1, y2, y3, out_valid, occ);
  modport slave  (input d, sel, in_valid, out_ready, bcast, output in_ready, y0, y1, y2, y3, out_valid, occ);
`else
  modport master (output d, sel, in_valid, out_ready, input in_ready, y0, y1, y2, y3, out_valid, occ);
  modport slave  (input d, sel, in_valid, out_ready, output in_ready, y0, y1, y2, y3, out_valid, occ);
`endif
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demux with a one-entry holding register per channel; DEMUX4_BCAST_EN adds broadcast
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  demux4_stream_if.slave bus
);
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       out_valid_q, out_valid_d;
  logic [2:0]       occ_q, occ_d;
  logic [3:0]       can_take, load;
  logic             bc, in_ready, accept;
  // A channel can take a word when empty or being drained this cycle; load wins over drain
  always_comb begin
`ifdef DEMUX4_BCAST_EN
    bc = bus.bcast;
`else
    bc = 1'b0;
`endif
    can_take = ~out_valid_q | bus.out_ready;
    in_ready = bc ? &can_take : can_take[bus.sel];
    accept = bus.in_valid && in_ready;
    load = !accept ? 4'b0000 : bc ? 4'b1111 : 4'b0001 << bus.sel;
    for (int i = 0; i < 4; i++) y_d[i] = load[i] ? bus.d : y_q[i];
    out_valid_d = load | (out_valid_q & ~bus.out_ready);
    occ_d = {2'b00, out_valid_d[0]} + {2'b00, out_valid_d[1]} + {2'b00, out_valid_d[2]} + {2'b00, out_valid_d[3]};
  end
  // Channel registers and occupancy; reset discards everything including a coincident accept
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      out_valid_q <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) y_q[i] <= y_d[i];
      out_valid_q <= out_valid_d;
      occ_q <= occ_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.y0        = y_q[0];
  assign bus.y1        = y_q[1];
  assign bus.y2        = y_q[2];
  assign bus.y3        = y_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.occ       = occ_q;
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed self-checking bench for demux4_stream
module tb_demux4_stream;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  demux4_stream_if #(.WIDTH(8)) bus ();
  demux4_stream #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ych(input logic [1:0] s);
    return s == 2'd0 ? bus.y0 : s == 2'd1 ? bus.y1 : s == 2'd2 ? bus.y2 : bus.y3;
  endfunction
  task automatic all_zero(input string tag);
    chk({tag, "_y0"}, 32'(bus.y0), 0);
    chk({tag, "_y1"}, 32'(bus.y1), 0);
    chk({tag, "_y2"}, 32'(bus.y2), 0);
    chk({tag, "_y3"}, 32'(bus.y3), 0);
    chk({tag, "_ov"}, 32'(bus.out_valid), 0);
    chk({tag, "_occ"}, 32'(bus.occ), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.d = '0;
    bus.sel = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
`ifdef DEMUX4_BCAST_EN
    bus.bcast = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    step();
    all_zero("reset");
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.d = 8'hA5; bus.sel = 2'd2;
    #1 chk("a5_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("a5_y2", 32'(bus.y2), 32'hA5);
    chk("a5_ov", 32'(bus.out_valid), 32'b0100);
    chk("a5_occ", 32'(bus.occ), 1);
    chk("sel2_full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    #1;
    bus.in_valid = 1'b1; bus.d = 8'h5A; bus.sel = 2'd0;
    #1 chk("sel0_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("5a_y0", 32'(bus.y0), 32'h5A);
    chk("5a_y2_kept", 32'(bus.y2), 32'hA5);
    chk("5a_ov", 32'(bus.out_valid), 32'b0101);
    chk("5a_occ", 32'(bus.occ), 2);
    bus.d = 8'h11; bus.sel = 2'd1;
    step();
    chk("11_y1", 32'(bus.y1), 32'h11);
    chk("11_ov", 32'(bus.out_valid), 32'b0111);
    chk("11_occ", 32'(bus.occ), 3);
    bus.d = 8'h22; bus.out_ready = 4'b0010;
    #1 chk("drain_load_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("22_y1", 32'(bus.y1), 32'h22);
    chk("22_ov", 32'(bus.out_valid), 32'b0111);
    chk("22_occ", 32'(bus.occ), 3);
    bus.in_valid = 1'b0;
    step();
    chk("drain1_ov", 32'(bus.out_valid), 32'b0101);
    chk("drain1_y1_kept", 32'(bus.y1), 32'h22);
    chk("drain1_occ", 32'(bus.occ), 2);
    bus.out_ready = 4'b1111;
    step();
    chk("drain_all_ov", 32'(bus.out_valid), 0);
    chk("drain_all_occ", 32'(bus.occ), 0);
    chk("drain_all_y0_kept", 32'(bus.y0), 32'h5A);
    for (int k = 1; k <= 8; k++) begin
      bus.in_valid = 1'b1; bus.d = 8'(k); bus.sel = 2'(k - 1);
      #1 chk($sformatf("rr%0d_in_ready", k), 32'(bus.in_ready), 1);
      step();
      chk($sformatf("rr%0d_y", k), 32'(ych(2'(k - 1))), 32'(k));
      chk($sformatf("rr%0d_ov", k), 32'(bus.out_valid), 32'(4'b0001 << ((k - 1) % 4)));
      chk($sformatf("rr%0d_occ", k), 32'(bus.occ), 1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("rr_end_ov", 32'(bus.out_valid), 0);
    bus.out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.d = 8'(8'h40 + k); bus.sel = 2'(k);
      step();
    end
    bus.in_valid = 1'b0;
    chk("fill_ov", 32'(bus.out_valid), 32'b1111);
    chk("fill_occ", 32'(bus.occ), 4);
    chk("fill_y3", 32'(bus.y3), 32'h43);
    chk("fill_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 4'b1111; bus.in_valid = 1'b1; bus.d = 8'h77; bus.sel = 2'd0; reset = 1'b1;
    step();
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    all_zero("midreset");
    chk("midreset_in_ready", 32'(bus.in_ready), 1);
`ifdef DEMUX4_BCAST_EN
    bus.bcast = 1'b1; bus.in_valid = 1'b1; bus.d = 8'h3C;
    #1 chk("bc_in_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("bc_y0", 32'(bus.y0), 32'h3C);
    chk("bc_y1", 32'(bus.y1), 32'h3C);
    chk("bc_y2", 32'(bus.y2), 32'h3C);
    chk("bc_y3", 32'(bus.y3), 32'h3C);
    chk("bc_ov", 32'(bus.out_valid), 32'b1111);
    chk("bc_occ", 32'(bus.occ), 4);
    bus.out_ready = 4'b1110;
    #1 chk("bc_stalled_in_ready", 32'(bus.in_ready), 0);
    bus.bcast = 1'b0; bus.sel = 2'd1;
    #1 chk("uc_other_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 4'b0000;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer for the datapath. It is the distributing counterpart to the 4-input select mux: it routes one input word to one of four outputs, chosen by `sel`. Each output owns a one-entry holding register with a valid/ready handshake, so four independent consumers can drain at their own rate without stalling each other. It sits between a shared producer (e.g. ALU/result bus) and four downstream consumers.

## Interface
- `WIDTH`, default 8, data width of input and every output.

- `clk` input 1, sole clock; all state updates on rising edge.
- `reset` input 1, synchronous, active-high; clears all state at the next rising edge.
- `d` input WIDTH, input data word.
- `sel` input 2, destination channel 0..3.
- `in_valid` input 1, producer offers `d`/`sel` this cycle.
- `in_ready` output 1, block accepts this cycle. Combinational from `sel`, `out_ready`, and internal state.
- `y0`..`y3` output WIDTH each, channel holding registers.
- `out_valid` output 4, bit i = `y<i>` holds an unconsumed word.
- `out_ready` input 4, bit i = consumer i takes `y<i>` this cycle.
- `occ` output 3, number of channels with `out_valid` set (0..4), registered.
- `bcast` input 1, present only with `DEMUX4_BCAST_EN`; see Configuration.

## Operation
- `can_take[i] = !out_valid[i] || out_ready[i]`.
- Unicast: `in_ready = can_take[sel]`; `accept = in_valid && in_ready`.
- Channel i update per edge, with priority top-down:
  - If `reset`: `y<i>` ← 0 and `out_valid[i]` ← 0.
  - Else if `accept && sel == i`: `y<i>` ← `d` and `out_valid[i]` ← 1.
  - Else if `out_valid[i] && out_ready[i]`: `out_valid[i]` ← 0. `y<i>` keeps its old value and is not cleared.
  - Else: hold.
- Simultaneous drain and load on the same channel: the load wins, `out_valid` stays 1 and the new word replaces the old one. Throughput is 1 word/cycle per channel.
- Only the selected channel affects `in_ready`. A full, stalled channel never blocks traffic to the other channels.
- Upstream contract: while `in_valid && !in_ready`, `d` and `sel` are held stable. Deasserting `in_valid` without a transfer is legal.
- `occ` is the popcount of the next-state `out_valid`, registered in the same edge.
- No state machine beyond the per-channel valid bits. Each channel is an EMPTY/FULL pair:
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain with no load.
  - FULL→FULL on load, with or without a drain.

## Timing
- Reset values: all `y*` = 0, `out_valid` = 4'b0000, `occ` = 0. `in_ready` = 1 after reset, because all channels are empty.
- Latency: a word accepted at edge k is on `y<sel>` with `out_valid` set from just after edge k. That is 1 cycle.
- `out_valid[i]` drops the cycle after the consumer handshake, unless a load coincides.
- Reset asserted mid-transfer: all pending words are discarded. No handshake completes on a reset edge, even if `in_valid && in_ready` is high.
- Combinational paths:
  - `out_ready` → `in_ready`
  - `sel` → `in_ready`
  - Upstream must not make `in_valid` depend combinationally on `in_ready`.

## Configuration
- `DEMUX4_BCAST_EN` defined:
  - Adds the `bcast` input.
  - When `bcast`=1, `sel` is ignored and `in_ready = &can_take`.
  - An accept loads `d` into all four channels and sets `out_valid` = 4'b1111. `occ` becomes 4.
  - When `bcast`=0, behaviour is unicast as above.
- `DEMUX4_BCAST_EN` undefined: the `bcast` port is absent and the block is unicast only.

## Test plan
- Reset then idle → all `y*`=0, `out_valid`=0000, `occ`=0, `in_ready`=1.
- Send `d`=0xA5 with `sel`=2, all `out_ready`=0 → next cycle `y2`=0xA5, `out_valid`=0100, `occ`=1. A second send to `sel`=2 sees `in_ready`=0. A send to `sel`=0 is accepted.
- Channel 1 full with 0x11. In the same cycle, `out_ready[1]`=1 and a send of 0x22 to `sel`=1 → accepted, `y1`=0x22, `out_valid[1]` stays 1. Then `out_ready[1]`=1 with no send → `out_valid[1]`=0 and `y1` still 0x22.
- Back-to-back 0x01..0x08 round-robin over `sel` 0..3 with `out_ready`=1111 → one accept per cycle, every word appears one cycle later on the matching channel, and `occ` never exceeds 4.
- Reset asserted while `out_valid`=1111 and `in_valid`=1 → next cycle everything is 0 and no word is accepted.
- With `DEMUX4_BCAST_EN`:
  - `bcast`=1, `d`=0x3C, all empty → all `y*`=0x3C, `out_valid`=1111, `occ`=4.
  - With one channel stalled full, `bcast`=1 gives `in_ready`=0.
